ring_count_meter: RTL and testbench

//  Downstream measurement stage for the instrumented Kogge-Stone adder.
//  - Enables the adder ring oscillator and counts rising edges of its chain output over a programmed gate window.
//  - Publishes the count, so firmware reads adder ring frequency (and so adder delay) over the LA bus.
//  - Sits between the instrumented adder and the wrapper's LA/IO mux.

---
 rtl/adder_meter_pkg.sv | 18 +
 rtl/ring_edge_sync.sv | 33 +++
 rtl/ring_count_meter.sv | 169 ++++++++++++++++
 tb/tb_ring_count_meter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_meter_pkg.sv
// Shared definitions for the adder ring-oscillator measurement stage.
// Holds the measurement FSM state encoding and the default widths and
// timing constants used by ring_count_meter and its testbench.
package adder_meter_pkg;

  localparam int COUNT_W_DEF       = 32;
  localparam int GATE_W_DEF        = 32;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_e;

endpackage

// File: rtl/ring_edge_sync.sv
// Synchronizer and rising-edge detector for the asynchronous ring output.
// ring samples pass through SYNC_STAGES flops, then one history flop; the
// rise pulse is high for one clock per synchronized 0->1 transition.
// Ports:
//   clk       in  system clock
//   rst_n     in  async active-low reset, clears every flop to 0
//   async_in  in  asynchronous input (adder chain_out)
//   rise      out one-cycle pulse on a synchronized rising edge
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ring_count_meter.sv
// Ring-oscillator edge counter for the instrumented Kogge-Stone adder.
// A run enables the ring, waits SETTLE_CYCLES for the synchronizer to
// prime, counts synchronized rising edges for gate_len cycles, then
// publishes the count with a one-cycle done pulse.
//
// Handshake: start is a level request sampled at each posedge while in
// IDLE or DONE and active=1; there is no ready signal and a request seen
// in SETTLE/MEASURE is dropped. done is a one-cycle valid for count and
// overflow, which then stay stable until the next accepted start.
//
// Ports:
//   wb_clk_i   in  system clock
//   rst_n      in  async active-low reset
//   active     in  project select; low forces IDLE and clears results
//   start      in  level start request
//   gate_len   in  measurement window in cycles, captured on accept
//   ring_in    in  asynchronous ring output
//   ring_en    out ring oscillator enable (SETTLE and MEASURE)
//   busy       out high in SETTLE/MEASURE/DONE
//   done       out one-cycle completion pulse
//   count      out last completed edge count
//   overflow   out edge counter saturated during the last run
//   state_dbg  out current FSM state for observation
module ring_count_meter
  import adder_meter_pkg::*;
#(
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic               active,
  input  logic               start,
  input  logic [GATE_W-1:0]  gate_len,
  input  logic               ring_in,
  output logic               ring_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output meter_state_e       state_dbg
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  meter_state_e         state_q;
  meter_state_e         state_nx;
  logic                 accept;
  logic [SETTLE_W-1:0]  settle_cnt_q;
  logic [GATE_W-1:0]    gate_cnt_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 overflow_q;
  logic                 rise;

  ring_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (wb_clk_i),
    .rst_n    (rst_n),
    .async_in (ring_in),
    .rise     (rise)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic. The settle and gate counters are down-counters that
  // exit on their 1->0 step, so each phase lasts exactly its loaded value.
  // The gate counter holds the captured gate_len through SETTLE, which is
  // how a zero window is recognised and MEASURE skipped.
  always_comb begin
    state_nx = state_q;
    accept   = 1'b0;
    if (!active) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_nx = SETTLE;
            accept   = 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_W'(1)) begin
            state_nx = (gate_cnt_q == '0) ? DONE : MEASURE;
          end
        end
        MEASURE: begin
          if (gate_cnt_q == GATE_W'(1)) begin
            state_nx = DONE;
          end
        end
        DONE: begin
          if (start) begin
            state_nx = SETTLE;
            accept   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Counters and results.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else if (!active) begin
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else if (accept) begin
      settle_cnt_q <= SETTLE_W'(SETTLE_CYCLES);
      gate_cnt_q   <= gate_len;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (state_q == SETTLE && settle_cnt_q != '0) begin
        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
      end
      if (state_q == MEASURE) begin
        if (gate_cnt_q != '0) begin
          gate_cnt_q <= gate_cnt_q - GATE_W'(1);
        end
        // An edge arriving with the counter already full is lost; flag it.
        if (rise) begin
          if (count_q == '1) begin
            overflow_q <= 1'b1;
          end else begin
            count_q <= count_q + COUNT_W'(1);
          end
        end
      end
    end
  end

  // Moore outputs.
  always_comb begin
    ring_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      SETTLE:  begin ring_en = 1'b1; busy = 1'b1; end
      MEASURE: begin ring_en = 1'b1; busy = 1'b1; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ring_count_meter.sv
// Directed testbench for ring_count_meter. A 32-bit and a 4-bit counter
// instance share all inputs; the ring model toggles every 4 clocks
// (period 8 clocks) with its edges offset from the clock edges.
module tb_ring_count_meter;
  import adder_meter_pkg::*;

  logic        wb_clk_i;
  logic        rst_n;
  logic        active;
  logic        start;
  logic [31:0] gate_len;
  logic        ring_in;
  logic        ring_run;

  logic        ring_en, busy, done, overflow;
  logic [31:0] count;
  meter_state_e state_dbg;

  logic        ring_en4, busy4, done4, overflow4;
  logic [3:0]  count4;
  meter_state_e state4;

  int checks = 0;
  int passed = 0;

  ring_count_meter dut (
    .wb_clk_i (wb_clk_i), .rst_n (rst_n), .active (active), .start (start),
    .gate_len (gate_len), .ring_in (ring_in), .ring_en (ring_en), .busy (busy),
    .done (done), .count (count), .overflow (overflow), .state_dbg (state_dbg)
  );

  ring_count_meter #(.COUNT_W(4)) dut4 (
    .wb_clk_i (wb_clk_i), .rst_n (rst_n), .active (active), .start (start),
    .gate_len (gate_len), .ring_in (ring_in), .ring_en (ring_en4), .busy (busy4),
    .done (done4), .count (count4), .overflow (overflow4), .state_dbg (state4)
  );

  // Clock and reset.
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Ring model: toggles every 40 ns (4 clocks), edges at 3 ns past a
  // multiple of 40 ns so they never coincide with a clock edge.
  initial begin
    ring_in = 1'b0;
    #3;
    forever begin
      #40;
      if (ring_run) ring_in = ~ring_in;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers.
  // Request a run on the next posedge; returns at the negedge after that
  // edge (cycle t+1) with start released and gate_len scrambled.
  task automatic do_start(input logic [31:0] len, input logic hold);
    @(negedge wb_clk_i);
    start    = 1'b1;
    gate_len = len;
    @(negedge wb_clk_i);
    if (!hold) start = 1'b0;
    gate_len = 32'd5;
  endtask

  // Advance negedge by negedge until done is seen or k reaches limit.
  task automatic wait_done(input int limit, inout int k, output bit seen);
    seen = 1'b0;
    forever begin
      if (done) begin
        seen = 1'b1;
        return;
      end
      if (k >= limit) return;
      @(negedge wb_clk_i);
      k++;
    end
  endtask

  task automatic test_reset();
    logic any_out;
    rst_n    = 1'b0;
    active   = 1'b1;
    start    = 1'b1;
    gate_len = 32'd80;
    ring_run = 1'b1;
    any_out  = 1'b0;
    repeat (12) begin
      @(negedge wb_clk_i);
      any_out = any_out | ring_en | busy | done | overflow | (count != 0);
    end
    checks++;
    if (any_out !== 1'b0) $display("FAIL reset_outputs: got some output=%b, expected all 0", any_out);
    else passed++;
    checks++;
    if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", state_dbg, IDLE);
    else passed++;
    start = 1'b0;
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_idle: busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_nominal();
    int k;
    bit seen;
    do_start(32'd80, 1'b0);
    k = 1;
    checks++;
    if (ring_en !== 1'b1 || busy !== 1'b1 || state_dbg !== SETTLE)
      $display("FAIL nominal_accept: ring_en=%b busy=%b state=%0d, expected 1 1 %0d", ring_en, busy, state_dbg, SETTLE);
    else passed++;
    wait_done(300, k, seen);
    checks++;
    if (!seen || k != 97) $display("FAIL nominal_done_cycle: seen=%b at t+%0d, expected t+97", seen, k);
    else passed++;
    checks++;
    if (count !== 32'd10 || overflow !== 1'b0 || ring_en !== 1'b0)
      $display("FAIL nominal_result: count=%0d ovf=%b ring_en=%b, expected 10 0 0", count, overflow, ring_en);
    else passed++;
    @(negedge wb_clk_i);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 32'd10)
      $display("FAIL nominal_after_done: done=%b busy=%b count=%0d, expected 0 0 10", done, busy, count);
    else passed++;
  endtask

  task automatic test_zero_gate();
    int k;
    bit seen;
    do_start(32'd0, 1'b0);
    k = 1;
    wait_done(100, k, seen);
    checks++;
    if (!seen || k != 17) $display("FAIL zero_gate_done_cycle: seen=%b at t+%0d, expected t+17", seen, k);
    else passed++;
    checks++;
    if (count !== 32'd0 || overflow !== 1'b0)
      $display("FAIL zero_gate_result: count=%0d ovf=%b, expected 0 0", count, overflow);
    else passed++;
  endtask

  task automatic test_saturation();
    int k;
    bit seen;
    do_start(32'd200, 1'b0);
    k = 1;
    wait_done(400, k, seen);
    checks++;
    if (!seen || k != 217 || done4 !== 1'b1)
      $display("FAIL sat_done_cycle: seen=%b at t+%0d done4=%b, expected t+217 1", seen, k, done4);
    else passed++;
    checks++;
    if (count4 !== 4'd15 || overflow4 !== 1'b1)
      $display("FAIL sat_narrow: count=%0d ovf=%b, expected 15 1", count4, overflow4);
    else passed++;
    checks++;
    if (count !== 32'd25 || overflow !== 1'b0)
      $display("FAIL sat_wide: count=%0d ovf=%b, expected 25 0", count, overflow);
    else passed++;
    @(negedge wb_clk_i);
    checks++;
    if (done4 !== 1'b0 || overflow4 !== 1'b1)
      $display("FAIL sat_hold: done4=%b ovf4=%b, expected 0 1", done4, overflow4);
    else passed++;
  endtask

  task automatic test_abort();
    int k;
    int pulses;
    bit seen;
    do_start(32'd80, 1'b0);
    repeat (29) @(negedge wb_clk_i);
    checks++;
    if (state_dbg !== MEASURE || count == 32'd0)
      $display("FAIL abort_pre: state=%0d count=%0d, expected MEASURE and nonzero", state_dbg, count);
    else passed++;
    active = 1'b0;
    @(negedge wb_clk_i);
    active = 1'b1;
    checks++;
    if (state_dbg !== IDLE || ring_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 32'd0 || overflow !== 1'b0)
      $display("FAIL abort_idle: state=%0d ring_en=%b busy=%b done=%b count=%0d ovf=%b, expected IDLE 0 0 0 0 0",
               state_dbg, ring_en, busy, done, count, overflow);
    else passed++;
    pulses = 0;
    repeat (100) begin
      @(negedge wb_clk_i);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_no_done: got %0d done pulses, expected 0", pulses);
    else passed++;
    do_start(32'd40, 1'b0);
    k = 1;
    wait_done(200, k, seen);
    checks++;
    if (!seen || k != 57 || count !== 32'd5 || overflow !== 1'b0)
      $display("FAIL abort_rerun: seen=%b at t+%0d count=%0d ovf=%b, expected t+57 5 0", seen, k, count, overflow);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    do_start(32'd16, 1'b1);
    gate_len = 32'd16;
    k = 1;
    wait_done(200, k, seen);
    checks++;
    if (!seen || k != 33 || count !== 32'd2)
      $display("FAIL b2b_first: seen=%b at t+%0d count=%0d, expected t+33 2", seen, k, count);
    else passed++;
    @(negedge wb_clk_i);
    k++;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || ring_en !== 1'b1 || state_dbg !== SETTLE || count !== 32'd0)
      $display("FAIL b2b_restart: done=%b busy=%b ring_en=%b state=%0d count=%0d, expected 0 1 1 %0d 0",
               done, busy, ring_en, state_dbg, SETTLE, count);
    else passed++;
    wait_done(300, k, seen);
    checks++;
    if (!seen || k != 66 || count !== 32'd2)
      $display("FAIL b2b_second: seen=%b at t+%0d count=%0d, expected t+66 2", seen, k, count);
    else passed++;
    start = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 32'd2)
      $display("FAIL b2b_stop: busy=%b done=%b count=%0d, expected 0 0 2", busy, done, count);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    do_start(32'd80, 1'b0);
    repeat (40) @(negedge wb_clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ring_en !== 1'b0 || busy !== 1'b0 || count !== 32'd0 || state_dbg !== IDLE)
      $display("FAIL reset_mid_run: ring_en=%b busy=%b count=%0d state=%0d, expected 0 0 0 IDLE",
               ring_en, busy, count, state_dbg);
    else passed++;
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(negedge wb_clk_i);
  endtask

  initial begin
    rst_n    = 1'b0;
    active   = 1'b0;
    start    = 1'b0;
    gate_len = '0;
    ring_run = 1'b1;
    test_reset();
    test_nominal();
    test_zero_gate();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
